// File: rtl/mm2s_pkg.sv
// Shared state encoding, status codes and AXI constants for the MM2S read engine.
package mm2s_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_DATA,
        S_STATUS
    } state_t;

    localparam logic [1:0] STS_OK  = 2'd0;
    localparam logic [1:0] STS_INT = 2'd1;
    localparam logic [1:0] STS_SLV = 2'd2;
    localparam logic [1:0] STS_DEC = 2'd3;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BOUNDARY_4K = 4096;

    function automatic logic [1:0] resp_to_sts(input logic [1:0] resp);
        case (resp)
            RESP_SLVERR: return STS_SLV;
            RESP_DECERR: return STS_DEC;
            RESP_OKAY, RESP_EXOKAY: return STS_OK;
            default: return STS_OK;
        endcase
    endfunction

endpackage

// File: rtl/mm2s_burst_calc.sv
// Beat count of the next read burst: the smallest of remaining beats,
// MAX_BURST and the beats left before the next 4 KB page boundary.
module mm2s_burst_calc
    import mm2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 26,
    parameter int MAX_BURST  = 16
) (
    input  logic [11:0]          page_offset,
    input  logic [LEN_WIDTH-1:0] beats_left,
    output logic [8:0]           beats
);

    localparam int LOG_BPB = $clog2(DATA_WIDTH / 8);

    logic [12:0] to_boundary;

    always_comb begin
        to_boundary = (13'(BOUNDARY_4K) - {1'b0, page_offset}) >> LOG_BPB;
        beats = 9'(MAX_BURST);
        if (32'(beats_left) < 32'(beats)) beats = 9'(beats_left);
        if (32'(to_boundary) < 32'(beats)) beats = 9'(to_boundary);
    end

endmodule

// File: rtl/mm2s_read_engine.sv
// MM2S read engine: splits one command into AXI4 INCR read bursts and
// repacks the returned R beats onto an AXI4-Stream master with TKEEP/TLAST.
module mm2s_read_engine
    import mm2s_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 26,
    parameter int MAX_BURST  = 16,
    parameter int ARID_VAL   = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    output logic                    sts_valid,
    input  logic                    sts_ready,
    output logic [1:0]              sts_err,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast
);

    localparam int BPB     = DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BPB - 1);
    localparam logic [LEN_WIDTH-1:0]  REM_MASK   = LEN_WIDTH'(BPB - 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beats_left_q;
    logic [1:0]             err_q;
    logic                   cmd_ready_q;
    logic [8:0]             burst_beats;

    logic                   tvalid_p1;
    logic [DATA_WIDTH-1:0]  tdata_p1;
    logic [BPB-1:0]         tkeep_p1;
    logic                   tlast_p1;

    logic cmd_fire, ar_fire, r_fire, sts_fire, bad_cmd, last_beat;
    logic [BPB-1:0] keep_final;

    // Only one burst is ever outstanding, so RID carries no information.
    logic unused_rid;
    assign unused_rid = ^m_axi_rid;

    function automatic logic [LEN_WIDTH-1:0] ceil_beats(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, len} + (LEN_WIDTH + 1)'(BPB - 1);
        return LEN_WIDTH'(sum >> LOG_BPB);
    endfunction

    function automatic logic [BPB-1:0] final_keep(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] rem;
        logic [BPB-1:0]       keep;
        rem = len & REM_MASK;
        for (int i = 0; i < BPB; i++)
            keep[i] = (rem == '0) || (LEN_WIDTH'(i) < rem);
        return keep;
    endfunction

    mm2s_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .page_offset (addr_q[11:0]),
        .beats_left  (beats_left_q),
        .beats       (burst_beats)
    );

    assign cmd_fire   = cmd_valid && cmd_ready_q;
    assign ar_fire    = m_axi_arvalid && m_axi_arready;
    assign r_fire     = m_axi_rvalid && m_axi_rready;
    assign sts_fire   = sts_valid && sts_ready;
    assign bad_cmd    = (len_q == '0) || ((addr_q & ALIGN_MASK) != '0);
    assign last_beat  = m_axi_rlast && (beats_left_q == '0);
    assign keep_final = final_keep(len_q);

    always_comb begin
        state_d       = state_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        sts_valid     = 1'b0;
        case (state_q)
            S_IDLE:   if (cmd_fire) state_d = S_CHECK;
            S_CHECK:  state_d = bad_cmd ? S_STATUS : S_ADDR;
            S_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = S_DATA;
            end
            S_DATA: begin
                m_axi_rready = !tvalid_p1 || m_axis_tready;
                if (m_axi_rvalid && m_axi_rready && m_axi_rlast)
                    state_d = (beats_left_q == '0) ? S_STATUS : S_ADDR;
            end
            S_STATUS: begin
                // Status waits until the final stream beat has left the output register.
                sts_valid = !tvalid_p1;
                if (sts_valid && sts_ready) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
            err_q        <= STS_OK;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == S_IDLE);
            if (cmd_fire) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                err_q  <= STS_OK;
            end
            if (state_q == S_CHECK) begin
                if (bad_cmd) err_q <= STS_INT;
                else         beats_left_q <= ceil_beats(len_q);
            end
            if (ar_fire) begin
                beats_left_q <= beats_left_q - LEN_WIDTH'(burst_beats);
                addr_q       <= addr_q + (ADDR_WIDTH'(burst_beats) << LOG_BPB);
            end
            // First error response wins; later ones are dropped.
            if (r_fire && err_q == STS_OK) err_q <= resp_to_sts(m_axi_rresp);
            if (sts_fire) err_q <= err_q;
        end
    end

    // Stage p1: stream output register, refilled in the same cycle it drains.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid_p1 <= 1'b0;
            tdata_p1  <= '0;
            tkeep_p1  <= '0;
            tlast_p1  <= 1'b0;
        end else if (r_fire) begin
            tvalid_p1 <= 1'b1;
            tdata_p1  <= m_axi_rdata;
            tkeep_p1  <= last_beat ? keep_final : '1;
            tlast_p1  <= last_beat;
        end else if (m_axis_tready) begin
            tvalid_p1 <= 1'b0;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign sts_err       = err_q;
    assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(burst_beats - 9'd1) : '0;
    assign m_axi_arsize  = m_axi_arvalid ? 3'(LOG_BPB) : '0;
    assign m_axi_arburst = m_axi_arvalid ? BURST_INCR : '0;
    assign m_axi_arid    = m_axi_arvalid ? ID_WIDTH'(ARID_VAL) : '0;
    assign m_axis_tvalid = tvalid_p1;
    assign m_axis_tdata  = tdata_p1;
    assign m_axis_tkeep  = tkeep_p1;
    assign m_axis_tlast  = tlast_p1;

endmodule
